// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the Sync_FIFO family (FIFO, writer, reader).
// The reader's output buffer depth is fixed at two entries to hide the FIFO's registered read.
package fifo_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int OBUF_DEPTH = 2;
  localparam int OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);

  typedef logic [OBUF_CNT_W-1:0] obuf_cnt_t;

  // True when one more word can be requested: buffered + in flight - leaving < depth.
  function automatic logic has_credit(input obuf_cnt_t count, input logic inflight,
                                      input logic pop);
    logic [OBUF_CNT_W:0] occ;
    occ = {1'b0, count} + {{OBUF_CNT_W{1'b0}}, inflight} - {{OBUF_CNT_W{1'b0}}, pop};
    return occ < (OBUF_CNT_W + 1)'(OBUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_obuf2.sv
// Two-entry circular output queue used by sync_fifo_reader.
// Push writes the tail, pop advances the head; both may occur in one cycle. Flush empties it.
module fifo_obuf2
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] head_o,
  output obuf_cnt_t         count_o
);

  logic [DWIDTH-1:0] mem_q [OBUF_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  obuf_cnt_t         count_q, count_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + obuf_cnt_t'(push_i) - obuf_cnt_t'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage is reset too, so m_data reads a defined zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side controller for Sync_FIFO: pops words and presents them on a valid/ready stream.
// A credit of two (buffered + in flight) lets it sustain one word per clock despite the read latency.
module sync_fifo_reader
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              busy
);

  logic             run_q;
  logic             inflight_q;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  obuf_cnt_t        count;
  logic             pop;
  logic             push;

  // Flush discards the returning word and suppresses both the pop and the counter step.
  assign pop  = m_valid && m_ready && !flush;
  assign push = inflight_q && !flush;

  // run_q holds off the first pop until the first clock edge after reset release.
  assign fifo_rd_en = run_q && !fifo_empty && !flush && has_credit(count, inflight_q, pop);

  assign xfer_cnt_d = xfer_cnt_q + CNT_W'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= fifo_rd_en;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  fifo_obuf2 #(
    .DWIDTH (DWIDTH)
  ) u_obuf (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .push_data_i (fifo_dout),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (m_data),
    .count_o     (count)
  );

  assign m_valid  = (count != '0);
  assign busy     = m_valid || inflight_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: a queue-based FIFO environment plus a transaction-level
// expectation queue (words read but not yet consumed, tagged with the edge they left the FIFO).
module tb_sync_fifo_reader;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;

  logic          fifo_rd_en, m_valid, busy;
  logic [DW-1:0] m_data;
  logic [15:0]   xfer_cnt;
  logic          fifo_rd_en4, m_valid4, busy4;
  logic [DW-1:0] m_data4;
  logic [3:0]    xfer_cnt4;

  always #5 clk = ~clk;

  sync_fifo_reader #(.DWIDTH(DW), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .xfer_cnt(xfer_cnt), .busy(busy)
  );

  // Narrow-counter copy sees identical stimulus; only its counter width differs.
  sync_fifo_reader #(.DWIDTH(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en4), .flush(flush), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .xfer_cnt(xfer_cnt4), .busy(busy4)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            pop_edge;
  } ent_t;

  ent_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            edge_n = 0;
  int            cyc = 0;
  int            vectors = 0;
  int            errors = 0;
  logic [15:0]   exp_cnt = '0;
  bit            acc_flag, rd_flag, obs_valid;
  logic [DW-1:0] acc_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A word is presentable once the edge after its FIFO read has captured it.
  function automatic bit exp_valid();
    return exp_q.size() > 0 && exp_q[0].pop_edge + 1 <= edge_n;
  endfunction

  task automatic fifo_write(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // One clock: drive at negedge, check, then advance environment and model after the edge.
  task automatic step(input logic rdy, input logic fl);
    bit ev;
    cyc++;
    m_ready = rdy;
    flush   = fl;
    #1;
    ev = exp_valid();
    obs_valid = m_valid;
    check("m_valid", m_valid, ev);
    check("m_valid4", m_valid4, ev);
    if (ev) check("m_data", m_data, exp_q[0].data);
    check("xfer_cnt", xfer_cnt, exp_cnt);
    check("xfer_cnt4", xfer_cnt4, exp_cnt[3:0]);
    check("busy", busy, exp_q.size() != 0);
    check("busy4", busy4, exp_q.size() != 0);
    check("rd_en_gated", fifo_rd_en && (fifo_empty || fl), 1'b0);
    check("rd_en4_gated", fifo_rd_en4 && (fifo_empty || fl), 1'b0);
    rd_flag  = fifo_rd_en;
    acc_flag = ev && rdy && !fl;
    if (acc_flag) acc_data = exp_q[0].data;
    @(posedge clk);
    #1;
    edge_n++;
    if (fl) begin
      exp_q.delete();
    end else if (acc_flag) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (rd_flag && fifo_q.size() > 0) begin
      fifo_dout = fifo_q.pop_front();
      exp_q.push_back('{data: fifo_dout, pop_edge: edge_n});
    end
    fifo_empty = (fifo_q.size() == 0);
    check("occupancy_le_2", exp_q.size() <= 2, 1'b1);
    @(negedge clk);
  endtask

  // mode 0: ready held high, 1: toggling, 2: random.
  task automatic drain(input int n, input int mode, output int got, output int span,
                       output int lat, output logic [DW-1:0] first_data);
    int first_acc, last_acc, first_rd, first_v;
    logic r;
    first_acc = -1; last_acc = -1; first_rd = -1; first_v = -1;
    got = 0;
    first_data = '0;
    for (int k = 0; k < 200 && got < n; k++) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = (k % 2 == 0);
      else                r = 1'($urandom_range(0, 1));
      step(r, 1'b0);
      if (rd_flag && first_rd < 0) first_rd = cyc;
      if (obs_valid && first_v < 0) first_v = cyc;
      if (acc_flag) begin
        if (got == 0) begin
          first_acc  = cyc;
          first_data = acc_data;
        end
        last_acc = cyc;
        got++;
      end
    end
    span = last_acc - first_acc;
    lat  = first_v - first_rd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got, span, lat;
    logic [DW-1:0] fd;

    // Reset state
    #2;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_xfer_cnt", xfer_cnt, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) step(1'b0, 1'b0);

    // 1: eight words, ready high: back-to-back delivery, 2-clock latency
    for (int i = 1; i <= 8; i++) fifo_write(16'(i * 16'h0011));
    drain(8, 0, got, span, lat, fd);
    check("t1_got", got, 8);
    check("t1_span", span, 7);
    check("t1_latency", lat, 2);
    check("t1_first", fd, 16'h0011);
    check("t1_xfer_cnt", xfer_cnt, 16'd8);
    check("t1_busy", busy, 1'b0);
    check("t1_empty", fifo_empty, 1'b1);

    // 2: ready low: only two words pulled, head held; then seamless drain
    for (int i = 1; i <= 8; i++) fifo_write(16'(i * 16'h0011));
    repeat (6) step(1'b0, 1'b0);
    check("t2_fifo_left", fifo_q.size(), 6);
    check("t2_valid", m_valid, 1'b1);
    check("t2_head", m_data, 16'h0011);
    drain(8, 0, got, span, lat, fd);
    check("t2_got", got, 8);
    check("t2_span", span, 7);
    check("t2_first", fd, 16'h0011);

    // 3: toggling ready
    for (int i = 1; i <= 8; i++) fifo_write(16'(i * 16'h0011));
    drain(8, 1, got, span, lat, fd);
    check("t3_got", got, 8);
    check("t3_first", fd, 16'h0011);

    // 4: flush with one word buffered and one returning from the FIFO
    for (int i = 1; i <= 8; i++) fifo_write(16'(i * 16'h0011));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("t4_valid_after_flush", m_valid, 1'b0);
    check("t4_busy_after_flush", busy, 1'b0);
    drain(6, 0, got, span, lat, fd);
    check("t4_got", got, 6);
    check("t4_first_after_flush", fd, 16'h0033);

    // 5: asynchronous reset mid-burst
    for (int i = 1; i <= 8; i++) fifo_write(16'(i * 16'h0011));
    repeat (4) step(1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = '0;
    check("t5_valid", m_valid, 1'b0);
    check("t5_rd_en", fifo_rd_en, 1'b0);
    check("t5_xfer_cnt", xfer_cnt, 16'h0000);
    check("t5_busy", busy, 1'b0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("t5_rd_en_hold", fifo_rd_en, 1'b0);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("t5_rd_en_release", fifo_rd_en, 1'b0);
    drain(fifo_q.size(), 0, got, span, lat, fd);

    // 6: random traffic up to 17 words since reset; 4-bit counter wraps to 1
    for (int k = 0; k < 400 && exp_cnt < 16'd17; k++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 1) == 1) fifo_write(16'($urandom));
      step(1'($urandom_range(0, 1)), 1'b0);
    end
    check("t6_xfer_cnt", xfer_cnt, 16'd17);
    check("t6_xfer_cnt4_wrap", xfer_cnt4, 4'd1);

    // Random traffic with occasional flush
    for (int k = 0; k < 300; k++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) fifo_write(16'($urandom));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
